// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use stalls, redirect flushes and
// memory-wait freezes, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs_addr,
   input  logic [4:0]       id_rt_addr,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             dx_mem_read,
   input  logic [4:0]       dx_rt_addr,
   input  logic             dx_branch_taken,
   input  logic             dx_jump,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             fd_write,
   output logic             fd_flush,
   output logic             dx_write,
   output logic             dx_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_WAIT} state_e;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       fcnt_q, fcnt_d;
   logic             ret_q, ret_d;   // 1: resume into FLUSH after a wait
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             luh, rd;

   assign luh = dx_mem_read && (dx_rt_addr != 5'd0) &&
                ((id_uses_rs && (id_rs_addr == dx_rt_addr)) ||
                 (id_uses_rt && (id_rt_addr == dx_rt_addr)));
   assign rd  = dx_branch_taken || dx_jump;

   always_comb begin
      pc_write  = 1'b1;
      fd_write  = 1'b1;
      fd_flush  = 1'b0;
      dx_write  = 1'b1;
      dx_bubble = 1'b0;
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      ret_d     = ret_q;

      if (mem_busy) begin
         pc_write = 1'b0;
         fd_write = 1'b0;
         dx_write = 1'b0;
         if (state_q != S_WAIT) begin
            ret_d   = (state_q == S_FLUSH);
            state_d = S_WAIT;
         end
      end else begin
         case (state_q)
            S_WAIT: begin
               state_d = ret_q ? S_FLUSH : S_RUN;
            end
            S_FLUSH: begin
               fd_flush  = 1'b1;
               dx_bubble = 1'b1;
               fcnt_d    = fcnt_q - 4'd1;
               if (fcnt_q <= 4'd1) state_d = S_RUN;
            end
            default: begin
               if (rd) begin
                  fd_flush  = 1'b1;
                  dx_bubble = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = S_FLUSH;
                     fcnt_d  = FLUSH_INIT;
                  end
               end else if (luh) begin
                  pc_write  = 1'b0;
                  fd_write  = 1'b0;
                  dx_bubble = 1'b1;
               end
            end
         endcase
      end

      // Reset drains the pipeline with NOPs regardless of state.
      if (rst) begin
         pc_write  = 1'b0;
         fd_write  = 1'b0;
         fd_flush  = 1'b1;
         dx_write  = 1'b1;
         dx_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         fcnt_q  <= 4'd0;
         ret_q   <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         ret_q   <= ret_d;
         if (!pc_write && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
         if (fd_flush && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard/stall/flush sequencer for the 5-stage core.
- Drives write-enables and bubble/flush controls for the PC, the F/D pipeline register and the D/X pipeline register, from decode-stage operand usage, D/X-stage load/branch/jump state and a data-memory busy flag.
- Inserts load-use stalls, multi-cycle redirect flushes and memory-wait freezes.
- Keeps saturating stall/flush counters for performance inspection.

Parameters:
- FLUSH_CYCLES, 2, bubbles inserted per taken branch/jump (legal range 1..15).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- id_rs_addr  input  5  rs field of the instruction in decode.
- id_rt_addr  input  5  rt field of the instruction in decode.
- id_uses_rs  input  1  decode instruction reads rs.
- id_uses_rt  input  1  decode instruction reads rt.
- dx_mem_read  input  1  buffered mem_read from the D/X register.
- dx_rt_addr  input  5  buffered rt_addr from the D/X register (load destination).
- dx_branch_taken  input  1  branch in X resolved taken this cycle.
- dx_jump  input  1  buffered jump from the D/X register.
- mem_busy  input  1  data memory cannot accept/complete this cycle.
- pc_write  output  1  PC register enable.
- fd_write  output  1  F/D register enable.
- fd_flush  output  1  F/D register loads a NOP.
- dx_write  output  1  D/X register enable.
- dx_bubble  output  1  D/X register loads a bubble (alu_op 3'h1, all control bits 0).
- stall_count  output  CNT_W  cycles with pc_write=0 since reset, saturating.
- flush_count  output  CNT_W  redirect bubbles inserted since reset, saturating.

Behaviour:
- States: RUN, FLUSH, WAIT. 4-bit flush counter fcnt. 1-bit saved return state ret.
- Control outputs are a combinational decode of state and inputs (same-cycle effect, zero latency). Counters are registered.
- Reset (rst=1 at posedge): state=RUN, fcnt=0, ret=RUN, stall_count=0, flush_count=0.
- While rst=1, outputs are forced to: pc_write=0, fd_write=0, fd_flush=1, dx_write=1, dx_bubble=1, so the pipeline fills with NOPs. Reset mid-FLUSH or mid-WAIT abandons the sequence.
- Load-use hazard (luh) = dx_mem_read & (dx_rt_addr!=0) & ((id_uses_rs & id_rs_addr==dx_rt_addr) | (id_uses_rt & id_rt_addr==dx_rt_addr)).
- Redirect (rd) = dx_branch_taken | dx_jump.
- Priority in every state: mem_busy > rd > luh.
- Default outputs: pc_write=1, fd_write=1, fd_flush=0, dx_write=1, dx_bubble=0.
- Any state with mem_busy=1:
  - All enables 0, no flush/bubble.
  - From RUN/FLUSH: ret<=state, state<=WAIT.
  - In WAIT: hold.
  - fcnt holds.
- WAIT with mem_busy=0: default outputs; state<=ret; no other event is evaluated this cycle.
- RUN with rd:
  - fd_flush=1, dx_bubble=1, pc_write=1 (target loads).
  - If FLUSH_CYCLES>1: state<=FLUSH, fcnt<=FLUSH_CYCLES-1.
- RUN with luh (no rd): pc_write=0, fd_write=0, dx_bubble=1. Stay in RUN. This is a one-cycle stall; M-to-X forwarding resolves the hazard on the next cycle.
- FLUSH without mem_busy:
  - fd_flush=1, dx_bubble=1; luh and rd are ignored (the flushed instructions are invalid).
  - fcnt<=fcnt-1; when fcnt==1, state<=RUN.
- stall_count increments each non-reset cycle with pc_write=0. flush_count increments each non-reset cycle with fd_flush=1 caused by rd or FLUSH. Both saturate at all-ones and do not wrap.
- Simultaneous rd and luh: the redirect wins; no stall is counted.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc_write=0, dx_bubble=1, fd_flush=1, both counters 0. After release with idle inputs -> pc_write=fd_write=dx_write=1.
- Load-use: dx_mem_read=1, dx_rt_addr=5, id_rs_addr=5, id_uses_rs=1 for 1 cycle -> pc_write=0, fd_write=0, dx_bubble=1 for exactly 1 cycle, stall_count=1. Same stimulus with dx_rt_addr=0 -> no stall.
- Branch, FLUSH_CYCLES=2: dx_branch_taken=1 for 1 cycle -> fd_flush=1 and dx_bubble=1 on that cycle and the next, then RUN; flush_count=2.
- Memory freeze mid-flush: rd, then mem_busy=1 for 3 cycles starting on the next cycle -> all enables 0 for 3 cycles; the remaining flush bubble is issued after mem_busy drops; stall_count=3.
- Priority and saturation: rd and luh together -> flush only, stall_count unchanged. With CNT_W=4, mem_busy held for 20 cycles -> stall_count stays at 15.
